dcache_2way: RTL and testbench

Parametrised two-way set-associative data cache with its own miss/write controller, replacing the direct-mapped data array plus external tag compare. It sits between the MEM stage and the memory line port. It supports:
- valid bits, per-set LRU replacement and global invalidate;
- byte (sign-extended) and word loads/stores;
- write-through, no-write-allocate stores over a request/acknowledge memory handshake.

---
 rtl/dcache_2way.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_2way.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way.sv
// Two-way set-associative data cache with write-through, no-write-allocate
// stores and a single-outstanding request/acknowledge memory line port.
module dcache_2way #(
  parameter int unsigned SETS       = 32,
  parameter int unsigned LINE_BYTES = 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_word,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             rdata,
  input  logic                    inv,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_word,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ack,
  input  logic [8*LINE_BYTES-1:0] mem_line
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned LW    = 8 * LINE_BYTES;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t state_q, state_d;

  logic [LW-1:0]            data_q [SETS][2];
  logic [TAG_W-1:0]         tag_q  [SETS][2];
  logic [SETS-1:0][1:0]     valid_q;
  logic [SETS-1:0]          lru_q;

  logic                     we_q, word_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              rdata_q;

  // Word accesses ignore the two low address bits.
  function automatic logic [OFF_W-1:0] eff_off(input logic [OFF_W-1:0] off,
                                               input logic word);
    return word ? {off[OFF_W-1:2], 2'b00} : off;
  endfunction

  function automatic logic [31:0] extract(input logic [LW-1:0] line,
                                          input logic [OFF_W-1:0] off,
                                          input logic word);
    logic [LW-1:0] sh;
    sh = line >> {off, 3'b000};
    return word ? sh[31:0] : {{24{sh[7]}}, sh[7:0]};
  endfunction

  function automatic logic [LW-1:0] merge(input logic [LW-1:0] line,
                                          input logic [OFF_W-1:0] off,
                                          input logic word,
                                          input logic [31:0] wd);
    logic [LW-1:0] r;
    int unsigned   o;
    logic [1:0]    k;
    r = line;
    o = 32'(off);
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      if (word ? (b >= o && b < o + 4) : (b == o)) begin
        k = 2'(b - o);
        r[8*b +: 8] = wd[8*k +: 8];
      end
    end
    return r;
  endfunction

  // Request-side lookup on the live address
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, hit_any, hit_way, accept;
  logic [LW-1:0]    hit_line;

  assign req_off  = eff_off(req_addr[OFF_W-1:0], req_word);
  assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = req_addr[ADDR_W-1:OFF_W+IDX_W];
  assign hit0     = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
  assign hit1     = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
  assign hit_any  = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = data_q[req_idx][hit_way];
  assign accept   = (state_q == S_IDLE) && !inv && req_valid;

  // Fill-side decode on the latched address
  logic [OFF_W-1:0] off_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] ltag_q;
  logic             victim, fill_we, store_hit_we;

  assign off_q        = eff_off(addr_q[OFF_W-1:0], word_q);
  assign idx_q        = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign ltag_q       = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign victim       = !valid_q[idx_q][0] ? 1'b0 :
                        !valid_q[idx_q][1] ? 1'b1 : lru_q[idx_q];
  assign fill_we      = (state_q == S_FILL) && mem_ack;
  assign store_hit_we = accept && req_we && hit_any;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !inv;
        if (accept) state_d = req_we ? S_WRITE : (hit_any ? S_RESP : S_FILL);
      end
      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = S_RESP;
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches driving the memory port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      word_q  <= req_word;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign mem_addr  = (state_q == S_FILL) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                         : addr_q;
  assign mem_word  = word_q;
  assign mem_wdata = wdata_q;

  // Load result register
  always_ff @(posedge clk) begin
    if (!rst_n)                            rdata_q <= '0;
    else if (accept && !req_we && hit_any) rdata_q <= extract(hit_line, req_off, req_word);
    else if (fill_we)                      rdata_q <= extract(mem_line, off_q, word_q);
    else if (state_q == S_WRITE && mem_ack) rdata_q <= '0;
  end

  assign rdata = rdata_q;

  // Valid and LRU bookkeeping; invalidate clears both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (state_q == S_IDLE && inv) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (accept && hit_any) lru_q[req_idx] <= ~hit_way;
      if (fill_we) begin
        valid_q[idx_q][victim] <= 1'b1;
        lru_q[idx_q]           <= ~victim;
      end
    end
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (store_hit_we)
        data_q[req_idx][hit_way] <= merge(hit_line, req_off, req_word, req_wdata);
      if (fill_we) begin
        data_q[idx_q][victim] <= mem_line;
        tag_q[idx_q][victim]  <= ltag_q;
      end
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Self-checking bench for dcache_2way: directed test-plan sequence followed
// by randomized traffic against a memory image plus per-set recency lists.
module tb_dcache_2way;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_word;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        inv;
  logic        mem_req, mem_we, mem_word;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_line;

  dcache_2way #(.SETS(32), .LINE_BYTES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .rdata(rdata), .inv(inv),
    .mem_req(mem_req), .mem_we(mem_we), .mem_word(mem_word),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_line(mem_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference: backing memory image and resident lines per set (MRU first)
  logic [63:0] mem [int unsigned];
  int unsigned resq [32][$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_get(input int unsigned la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom};
    return mem[la];
  endfunction

  function automatic logic [31:0] load_val(input logic [63:0] line,
                                           input logic [31:0] addr, input logic word);
    int unsigned off;
    logic [63:0] v;
    off = addr % 8;
    if (word) off = off & 4;
    v = line >> (8 * off);
    return word ? v[31:0] : {{24{v[7]}}, v[7:0]};
  endfunction

  function automatic void mem_write(input int unsigned la, input logic [31:0] addr,
                                    input logic word, input logic [31:0] wd);
    logic [63:0] line;
    int unsigned off, n;
    line = mem_get(la);
    off  = addr % 8;
    if (word) off = off & 4;
    n = word ? 4 : 1;
    for (int unsigned k = 0; k < n; k++) line[8*(off+k) +: 8] = wd[8*k +: 8];
    mem[la] = line;
  endfunction

  function automatic logic resident(input int unsigned la);
    int unsigned s;
    s = (la / 8) % 32;
    foreach (resq[s][i]) if (resq[s][i] == la) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void touch(input int unsigned la);
    int unsigned s;
    s = (la / 8) % 32;
    for (int i = resq[s].size() - 1; i >= 0; i--)
      if (resq[s][i] == la) resq[s].delete(i);
    resq[s].push_front(la);
    if (resq[s].size() > 2) void'(resq[s].pop_back());
  endfunction

  function automatic void clear_model();
    for (int s = 0; s < 32; s++) resq[s].delete();
  endfunction

  // One full transaction, checking every cycle until the response pulse.
  task automatic txn(input logic we, input logic word, input logic [31:0] addr,
                     input logic [31:0] wd, input int unsigned dly,
                     output logic [31:0] got, output logic obs_miss);
    int unsigned la;
    logic        res, miss;
    logic [31:0] exp_rd, exp_addr;
    la       = addr & ~32'h7;
    res      = resident(la);
    miss     = we || !res;
    exp_rd   = we ? 32'h0 : load_val(mem_get(la), addr, word);
    exp_addr = we ? addr : la;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("resp_valid_idle", resp_valid, 0);
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    obs_miss  = mem_req;
    if (miss) begin
      for (int unsigned c = 0; c <= dly; c++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, exp_addr);
        if (we) begin
          chk("mem_wdata", mem_wdata, wd);
          chk("mem_word", mem_word, word);
        end
        chk("resp_early", resp_valid, 0);
        if (c == dly) begin
          mem_ack  = 1'b1;
          mem_line = we ? {$urandom, $urandom} : mem_get(la);
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("rdata", rdata, exp_rd);
    chk("mem_req_resp", mem_req, 0);
    got = rdata;
    if (!we) touch(la);
    else begin
      if (res) touch(la);
      mem_write(la, addr, word, wd);
    end
  endtask

  logic [31:0] got;
  logic        m;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; inv = 1'b0; mem_ack = 1'b0; mem_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_word", mem_word, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    mem[32'h100] = 64'h8877665544332211;
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_w100", got, 32'h44332211); chk("lit_w100_miss", m, 1);
    txn(0, 1, 32'h104, 0, 0, got, m); chk("lit_w104", got, 32'h88776655); chk("lit_w104_hit", m, 0);
    txn(0, 0, 32'h107, 0, 0, got, m); chk("lit_b107", got, 32'hFFFFFF88);
    txn(0, 0, 32'h100, 0, 0, got, m); chk("lit_b100", got, 32'h00000011);
    txn(0, 1, 32'h200, 0, 1, got, m); chk("lit_200_miss", m, 1);
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_100_hit", m, 0);
    txn(0, 1, 32'h300, 0, 2, got, m); chk("lit_300_miss", m, 1);
    txn(0, 1, 32'h300, 0, 0, got, m); chk("lit_300_hit", m, 0);
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_100_hit2", m, 0);
    txn(0, 1, 32'h200, 0, 0, got, m); chk("lit_200_evicted", m, 1);
    txn(1, 1, 32'h100, 32'hDEADBEEF, 1, got, m);
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_st_reload", got, 32'hDEADBEEF); chk("lit_st_hit", m, 0);
    txn(1, 1, 32'h400, 32'h12345678, 0, got, m);
    txn(0, 1, 32'h400, 0, 0, got, m); chk("lit_400_noalloc", m, 1); chk("lit_400_data", got, 32'h12345678);

    // Invalidate: not ready that cycle, request ignored, everything misses after
    @(negedge clk);
    inv = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 32'h100;
    #1 chk("inv_not_ready", req_ready, 0);
    @(negedge clk);
    inv = 1'b0; req_valid = 1'b0;
    chk("inv_no_resp", resp_valid, 0);
    chk("inv_no_memreq", mem_req, 0);
    clear_model();
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_inv_miss", m, 1);

    // Reset while a fill is outstanding, then a stray ack in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_word = 1'b1; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_fill_req", mem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_memreq", mem_req, 0);
    chk("mid_rst_resp", resp_valid, 0);
    mem_ack = 1'b1; mem_line = {$urandom, $urandom};
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_resp", resp_valid, 0);
    chk("late_ack_memreq", mem_req, 0);
    clear_model();
    txn(0, 1, 32'h100, 0, 0, got, m); chk("lit_rst_miss", m, 1);

    // Randomized traffic over a small address pool to force set conflicts
    for (int n = 0; n < 400; n++) begin
      logic        rw, rword;
      logic [31:0] ra, off;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        inv = 1'b1;
        #1 chk("rnd_inv_ready", req_ready, 0);
        @(negedge clk);
        inv = 1'b0;
        clear_model();
      end
      rw    = ($urandom_range(0, 9) < 3);
      rword = $urandom_range(0, 1) == 1;
      off   = $urandom_range(0, 7);
      if (rword) off = off & 32'h4;
      ra = 32'h100 * $urandom_range(0, 3) + 32'h8 * $urandom_range(0, 3) + off;
      txn(rw, rword, ra, $urandom, $urandom_range(0, 3), got, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
